// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-and-add multiplier, one partial product per cycle, WIDTH-cycle run
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*WIDTH-1:0] p_q, p_d, addend;
  logic [CW-1:0]      count_q, count_d;
  assign addend = {{WIDTH{1'b0}}, mcand_q} << count_q;
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    p_d      = p_q;
    count_d  = count_q;
    case (state_q)
      IDLE: if (start) begin
        mcand_d  = A;
        mplier_d = B;
        p_d      = '0;
        count_d  = '0;
        state_d  = RUN;
      end
      RUN: begin
        p_d      = mplier_q[0] ? p_q + addend : p_q;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        state_d  = (count_q == CW'(WIDTH - 1)) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      p_q      <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      p_q      <= p_d;
      count_q  <= count_d;
    end
  end
  assign P    = p_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed vectors; expected products and done cycles queued, checked by a done monitor
module tb_seq_multiplier;
  logic        clock = 0, reset_L = 0, start = 0;
  logic [7:0]  A = 0, B = 0;
  logic [15:0] P;
  logic        busy, done;
  int          cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [15:0] p; int dc;} exp_t;
  exp_t q[$];

  seq_multiplier #(.WIDTH(8)) dut (.clock(clock), .reset_L(reset_L), .start(start),
    .A(A), .B(B), .P(P), .busy(busy), .done(done));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // each accepted start must produce exactly one done, 8 edges later, with the queued product
  always @(negedge clock) begin
    exp_t e;
    if (reset_L && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with P=%0d expected no done", P);
      end else begin
        e = q.pop_front();
        chk("done_P", int'(P), int'(e.p));
        chk("done_cycle", cyc, e.dc);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    @(negedge clock);
    start = 1; A = a; B = b;
    @(posedge clock);
    #1 q.push_back('{p, cyc + 8});
    @(negedge clock);
    start = 0; A = 8'($urandom); B = 8'($urandom);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    int n, n0;
    #2;
    chk("rst_P", int'(P), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    start = 1; A = 9; B = 9;
    repeat (3) @(negedge clock);
    chk("rst_clk_P", int'(P), 0);
    chk("rst_clk_busy", int'(busy), 0);
    chk("rst_clk_done", int'(done), 0);
    start = 0;
    reset_L = 1;
    repeat (2) @(negedge clock);

    issue(13, 11, 143);
    n = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) n++;
      @(negedge clock);
    end
    chk("busy_cycles", n, 8);
    chk("busy_at_done", int'(busy), 0);
    drain("op13x11");
    repeat (3) @(negedge clock);
    chk("hold_P", int'(P), 143);

    issue(255, 255, 16'hFE01);
    drain("op255x255");
    issue(0, 200, 0);
    drain("op0x200");
    issue(200, 0, 0);
    drain("op200x0");

    issue(7, 6, 42);
    repeat (3) @(negedge clock);
    start = 1; A = 3; B = 3;
    @(negedge clock);
    start = 0;
    drain("op7x6");
    repeat (5) @(negedge clock);
    chk("ignored_start_busy", int'(busy), 0);
    chk("ignored_start_P", int'(P), 42);

    issue(100, 100, 10000);
    repeat (4) @(posedge clock);
    #2 reset_L = 0;
    q.delete();
    #1;
    chk("abort_P", int'(P), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (2) @(negedge clock);
    reset_L = 1;
    repeat (12) @(negedge clock);
    issue(5, 5, 25);
    drain("op5x5");

    @(negedge clock);
    start = 1; A = 2; B = 3;
    @(posedge clock);
    #1 n0 = cyc;
    q.push_back('{16'd6, n0 + 8});
    q.push_back('{16'd6, n0 + 18});
    q.push_back('{16'd6, n0 + 28});
    repeat (24) @(posedge clock);
    @(negedge clock);
    start = 0;
    drain("held_start");
    repeat (4) @(negedge clock);
    chk("final_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
